// File: rtl/bitbalance_enumerator.sv
// Streams every WIDTH-bit word with exactly k ones, in ascending order, over valid/ready.
// Optional self-checker enabled by defining BITBAL_ENUM_CHECK_EN.
module bitbalance_enumerator #(
   parameter int WIDTH = 8,
   parameter int CW    = 4,
   parameter int IW    = 7
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [CW-1:0]    req_count,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_word,
   output logic             out_last,
   output logic [IW-1:0]    out_index,
   output logic             err,
   output logic             chk_fail
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    k_q, k_d;
   logic [WIDTH-1:0] word_q, word_d;
   logic [IW-1:0]    index_q, index_d;
   logic             err_q, err_d;

   logic [WIDTH:0]   ones_run, ones_req;
   logic [WIDTH-1:0] last_word;
   logic [WIDTH:0]   x_ext, c_ext, r_ext, next_ext;
   int               tz;
   logic             is_last;
   logic             handshake;
   logic             unused_bits;

   // Masks for the first word of a new request and the last word of the running sequence.
   always_comb begin
      ones_run  = ((WIDTH+1)'(1) << k_q) - (WIDTH+1)'(1);
      ones_req  = ((WIDTH+1)'(1) << req_count) - (WIDTH+1)'(1);
      last_word = ones_run[WIDTH-1:0] << (WIDTH - int'(k_q));
   end

   // Gosper's hack, one bit wider than the word so the carry out of x + c is kept.
   always_comb begin
      x_ext = {1'b0, word_q};
      c_ext = x_ext & (~x_ext + (WIDTH+1)'(1));
      r_ext = x_ext + c_ext;
      tz    = 0;
      for (int i = WIDTH; i >= 0; i--) begin
         if (c_ext[i]) tz = i;
      end
      next_ext = (((r_ext ^ x_ext) >> 2) >> tz) | r_ext;
   end

   assign unused_bits = ^{next_ext[WIDTH], ones_run[WIDTH], ones_req[WIDTH]};
   assign is_last     = (state_q == RUN) && (word_q == last_word);
   assign handshake   = (state_q == RUN) && out_ready;

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      word_d  = word_q;
      index_d = index_q;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               if (int'(req_count) > WIDTH) begin
                  err_d = 1'b1;
               end else begin
                  k_d     = req_count;
                  word_d  = ones_req[WIDTH-1:0];
                  index_d = '0;
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            if (out_ready) begin
               if (is_last) begin
                  state_d = IDLE;
               end else begin
                  word_d  = next_ext[WIDTH-1:0];
                  index_d = index_q + IW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         k_q     <= '0;
         word_q  <= '0;
         index_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         word_q  <= word_d;
         index_q <= index_d;
         err_q   <= err_d;
      end
   end

   assign req_ready = (state_q == IDLE);
   assign out_valid = (state_q == RUN);
   assign out_last  = is_last;
   assign out_word  = word_q;
   assign out_index = index_q;
   assign err       = err_q;

`ifdef BITBAL_ENUM_CHECK_EN
   logic [WIDTH-1:0] prev_q, prev_d;
   logic             chk_fail_q, chk_fail_d;
   logic             bad;

   function automatic int popcnt(input logic [WIDTH-1:0] v);
      int n;
      n = 0;
      for (int i = 0; i < WIDTH; i++) begin
         if (v[i]) n++;
      end
      return n;
   endfunction

   // Each accepted beat must carry k ones and be strictly above the previous beat.
   always_comb begin
      bad        = 1'b0;
      prev_d     = prev_q;
      if (handshake) begin
         if (popcnt(word_q) != int'(k_q)) bad = 1'b1;
         if ((index_q != '0) && (word_q <= prev_q)) bad = 1'b1;
         prev_d = word_q;
      end
      chk_fail_d = chk_fail_q | bad;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev_q     <= '0;
         chk_fail_q <= 1'b0;
      end else begin
         prev_q     <= prev_d;
         chk_fail_q <= chk_fail_d;
      end
   end

   assign chk_fail = chk_fail_q;
`else
   assign chk_fail = 1'b0;
`endif

endmodule

// File: tb/tb_bitbalance_enumerator.sv
// Testbench for bitbalance_enumerator: a list-based reference model checked every cycle,
// directed requests from the test plan, then randomized requests and backpressure.
module tb_bitbalance_enumerator;

   localparam int W  = 8;
   localparam int CW = 4;
   localparam int IW = 7;

   logic          clk;
   logic          reset;
   logic          req_valid;
   logic          req_ready;
   logic [CW-1:0] req_count;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_word;
   logic          out_last;
   logic [IW-1:0] out_index;
   logic          err;
   logic          chk_fail;

   bitbalance_enumerator #(.WIDTH(W), .CW(CW), .IW(IW)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_count (req_count),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_word  (out_word),
      .out_last  (out_last),
      .out_index (out_index),
      .err       (err),
      .chk_fail  (chk_fail)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model: the full expected sequence as a list, plus a pointer into it.
   int unsigned exp_q[$];
   int          ptr        = 0;
   bit          mdl_active = 1'b0;
   bit          mdl_err    = 1'b0;
   int          mdl_k      = 0;
   int          mdl_beats  = 0;
   int          ready_mode = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic build(input int k);
      exp_q.delete();
      for (int w = 0; w < (1 << W); w++) begin
         if ($countones(w) == k) exp_q.push_back(w);
      end
   endtask

   // Compare on the falling edge, then advance the model using the inputs the next rising edge sees.
   always @(negedge clk) begin
      bit new_err;
      if (reset) begin
         mdl_active = 1'b0;
         mdl_err    = 1'b0;
      end
      check("out_valid", int'(out_valid), int'(mdl_active));
      check("req_ready", int'(req_ready), int'(!mdl_active));
      check("err", int'(err), int'(mdl_err));
      check("chk_fail", int'(chk_fail), 0);
      if (mdl_active) begin
         check("out_word", int'(out_word), int'(exp_q[ptr]));
         check("out_index", int'(out_index), ptr);
         check("out_last", int'(out_last), int'(ptr == exp_q.size() - 1));
         check("popcount", $countones(out_word), mdl_k);
      end else begin
         check("out_last_idle", int'(out_last), 0);
      end
      new_err = 1'b0;
      if (!reset) begin
         if (!mdl_active) begin
            if (req_valid) begin
               if (int'(req_count) > W) begin
                  new_err = 1'b1;
               end else begin
                  mdl_k      = int'(req_count);
                  build(mdl_k);
                  ptr        = 0;
                  mdl_beats  = 0;
                  mdl_active = 1'b1;
               end
            end
         end else if (out_ready) begin
            mdl_beats++;
            if (ptr == exp_q.size() - 1) mdl_active = 1'b0;
            else ptr++;
         end
      end
      mdl_err = new_err;
   end

   // Consumer backpressure: 0 = always ready, 1 = toggle each cycle, 2 = random.
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ~out_ready;
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   task automatic applyStimulus(input int k, input int mode, input int reset_after);
      int budget;
      ready_mode = mode;
      req_count  = CW'(k);
      req_valid  = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      budget    = 0;
      while ((mdl_active || mdl_err) && budget < 600) begin
         if (reset_after > 0 && mdl_active && mdl_beats >= reset_after) begin
            reset = 1'b1;
            #1;
            check("rst_out_valid", int'(out_valid), 0);
            check("rst_out_word", int'(out_word), 0);
            check("rst_out_index", int'(out_index), 0);
            check("rst_req_ready", int'(req_ready), 1);
            @(posedge clk);
            #1;
            reset = 1'b0;
         end else begin
            @(posedge clk);
            #1;
            budget++;
         end
      end
      if (budget >= 600) check("timeout", 1, 0);
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput();
      int counts[9] = '{1, 8, 28, 56, 70, 56, 28, 8, 1};
      int k2[5]     = '{'h03, 'h05, 'h06, 'h09, 'h0A};
      int k7[8]     = '{'h7F, 'hBF, 'hDF, 'hEF, 'hF7, 'hFB, 'hFD, 'hFE};
      for (int k = 0; k <= W; k++) begin
         build(k);
         check("model_len", exp_q.size(), counts[k]);
      end
      build(2);
      for (int i = 0; i < 5; i++) check("model_k2", int'(exp_q[i]), k2[i]);
      check("model_k2_last", int'(exp_q[27]), 'hC0);
      build(7);
      for (int i = 0; i < 8; i++) check("model_k7", int'(exp_q[i]), k7[i]);
      build(1);
      check("model_k1_last", int'(exp_q[7]), 'h80);
   endtask

   initial begin
      reset     = 1'b1;
      req_valid = 1'b0;
      req_count = '0;
      checkOutput();
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      check("reset_out_valid", int'(out_valid), 0);
      check("reset_req_ready", int'(req_ready), 1);
      check("reset_out_word", int'(out_word), 0);
      check("reset_err", int'(err), 0);
      @(posedge clk);
      #1;

      applyStimulus(0, 0, 0);
      applyStimulus(8, 0, 0);
      applyStimulus(1, 0, 0);
      applyStimulus(2, 1, 0);
      applyStimulus(9, 0, 0);
      applyStimulus(4, 2, 10);
      applyStimulus(7, 0, 0);

      for (int n = 0; n < 20; n++) begin
         applyStimulus(int'($urandom_range(0, 9)), int'($urandom_range(0, 2)), 0);
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
